alu_cdb_issue_unit: RTL and testbench

- ALU functional-unit front/back end.
- Accepts issued instruction packets from the issue stage under a valid/ready handshake and evaluates the integer ALU operation.
- Buffers results in a small in-order FIFO and arbitrates them onto the common data bus (CDB) via a req/grant handshake.
- Sits between the RS issue logic and the CDB arbiter. Handles flush on branch mispredict.

---
 rtl/alu_cdb_issue_unit.sv | 138 +++++++++++++
 tb/tb_alu_cdb_issue_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cdb_issue_unit.sv
// ALU functional unit: evaluates issued packets, buffers results in an in-order
// FIFO and presents the head to the CDB arbiter under a req/grant handshake.
module alu_cdb_issue_unit #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned PREG_W = 6,
  parameter int unsigned ROB_W  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [31:0]       issue_opa,
  input  logic [31:0]       issue_opb,
  input  logic [3:0]        issue_func,
  input  logic [PREG_W-1:0] issue_dest_preg,
  input  logic [ROB_W-1:0]  issue_rob_idx,
  input  logic              squash,
  output logic              cdb_req,
  input  logic              cdb_grant,
  output logic [31:0]       cdb_data,
  output logic [PREG_W-1:0] cdb_preg,
  output logic [ROB_W-1:0]  cdb_rob_idx,
  output logic              busy
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [3:0] FuncAdd  = 4'd0;
  localparam logic [3:0] FuncSub  = 4'd1;
  localparam logic [3:0] FuncAnd  = 4'd2;
  localparam logic [3:0] FuncOr   = 4'd3;
  localparam logic [3:0] FuncXor  = 4'd4;
  localparam logic [3:0] FuncSlt  = 4'd5;
  localparam logic [3:0] FuncSltu = 4'd6;
  localparam logic [3:0] FuncSll  = 4'd7;
  localparam logic [3:0] FuncSrl  = 4'd8;
  localparam logic [3:0] FuncSra  = 4'd9;

  logic [31:0]       data_q [DEPTH];
  logic [31:0]       data_d [DEPTH];
  logic [PREG_W-1:0] preg_q [DEPTH];
  logic [PREG_W-1:0] preg_d [DEPTH];
  logic [ROB_W-1:0]  rob_q  [DEPTH];
  logic [ROB_W-1:0]  rob_d  [DEPTH];

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic [31:0] alu_res;
  logic [4:0]  shamt;
  logic        not_empty;
  logic        push;
  logic        pop;

  assign shamt = issue_opb[4:0];

  always_comb begin
    alu_res = 32'hfacebeec;
    case (issue_func)
      FuncAdd:  alu_res = issue_opa + issue_opb;
      FuncSub:  alu_res = issue_opa - issue_opb;
      FuncAnd:  alu_res = issue_opa & issue_opb;
      FuncOr:   alu_res = issue_opa | issue_opb;
      FuncXor:  alu_res = issue_opa ^ issue_opb;
      FuncSlt:  alu_res = {31'b0, ($signed(issue_opa) < $signed(issue_opb))};
      FuncSltu: alu_res = {31'b0, (issue_opa < issue_opb)};
      FuncSll:  alu_res = issue_opa << shamt;
      FuncSrl:  alu_res = issue_opa >> shamt;
      FuncSra:  alu_res = $unsigned($signed(issue_opa) >>> shamt);
      default:  alu_res = 32'hfacebeec;
    endcase
  end

  assign not_empty   = (count_q != '0);
  assign issue_ready = (count_q < CntW'(DEPTH));
  assign busy        = not_empty;
  assign cdb_req     = not_empty && !squash;

  // Head is zeroed when empty so stale entries never leak onto the bus.
  assign cdb_data    = not_empty ? data_q[head_q] : 32'd0;
  assign cdb_preg    = not_empty ? preg_q[head_q] : '0;
  assign cdb_rob_idx = not_empty ? rob_q[head_q]  : '0;

  assign push = issue_valid && issue_ready && !squash;
  assign pop  = cdb_req && cdb_grant;

  always_comb begin
    data_d  = data_q;
    preg_d  = preg_q;
    rob_d   = rob_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (squash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        data_d[tail_q] = alu_res;
        preg_d[tail_q] = issue_dest_preg;
        rob_d[tail_q]  = issue_rob_idx;
        tail_d         = tail_q + PtrW'(1);
      end
      if (pop) begin
        head_d = head_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
        preg_q[i] <= '0;
        rob_q[i]  <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      data_q  <= data_d;
      preg_q  <= preg_d;
      rob_q   <= rob_d;
    end
  end

endmodule

// File: tb/tb_alu_cdb_issue_unit.sv
// Directed bench for alu_cdb_issue_unit: ALU results, FIFO ordering,
// backpressure, squash and reset behaviour.
module tb_alu_cdb_issue_unit;

  logic        clock;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_opa;
  logic [31:0] issue_opb;
  logic [3:0]  issue_func;
  logic [5:0]  issue_dest_preg;
  logic [4:0]  issue_rob_idx;
  logic        squash;
  logic        cdb_req;
  logic        cdb_grant;
  logic [31:0] cdb_data;
  logic [5:0]  cdb_preg;
  logic [4:0]  cdb_rob_idx;
  logic        busy;

  int errors = 0;
  int checks = 0;
  logic [31:0] bcast_q[$];

  alu_cdb_issue_unit #(.DEPTH(2), .PREG_W(6), .ROB_W(5)) dut (
    .clock           (clock),
    .reset           (reset),
    .issue_valid     (issue_valid),
    .issue_ready     (issue_ready),
    .issue_opa       (issue_opa),
    .issue_opb       (issue_opb),
    .issue_func      (issue_func),
    .issue_dest_preg (issue_dest_preg),
    .issue_rob_idx   (issue_rob_idx),
    .squash          (squash),
    .cdb_req         (cdb_req),
    .cdb_grant       (cdb_grant),
    .cdb_data        (cdb_data),
    .cdb_preg        (cdb_preg),
    .cdb_rob_idx     (cdb_rob_idx),
    .busy            (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Records every value actually consumed by the arbiter.
  always @(posedge clock) begin
    if (reset && cdb_req && cdb_grant) bcast_q.push_back(cdb_data);
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_pkt(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] p, input logic [4:0] r);
    issue_func      = f;
    issue_opa       = a;
    issue_opb       = b;
    issue_dest_preg = p;
    issue_rob_idx   = r;
    issue_valid     = 1'b1;
  endtask

  // Single packet through an idle unit with grant held high.
  task automatic op_check(input string tag, input logic [3:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    set_pkt(f, a, b, 6'd9, 5'd4);
    tick();
    issue_valid = 1'b0;
    #1;
    chk({tag, "_req"}, 32'(cdb_req), 32'd1);
    chk(tag, cdb_data, exp);
    tick();
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    issue_valid = 1'b0;
    issue_opa = '0;
    issue_opb = '0;
    issue_func = '0;
    issue_dest_preg = '0;
    issue_rob_idx = '0;
    squash = 1'b0;
    cdb_grant = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rst_req", 32'(cdb_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(issue_ready), 32'd1);
    chk("rst_data", cdb_data, 32'd0);
    chk("rst_preg", 32'(cdb_preg), 32'd0);
    chk("rst_rob", 32'(cdb_rob_idx), 32'd0);

    // First transaction, latency one cycle.
    cdb_grant = 1'b1;
    set_pkt(4'd0, 32'h7fffffff, 32'd1, 6'd5, 5'd3);
    tick();
    issue_valid = 1'b0;
    #1;
    chk("add_req", 32'(cdb_req), 32'd1);
    chk("add_data", cdb_data, 32'h80000000);
    chk("add_preg", 32'(cdb_preg), 32'd5);
    chk("add_rob", 32'(cdb_rob_idx), 32'd3);
    tick();
    chk("add_busy", 32'(busy), 32'd0);
    chk("add_req0", 32'(cdb_req), 32'd0);

    op_check("sub", 4'd1, 32'd3, 32'd5, 32'hfffffffe);
    op_check("and", 4'd2, 32'hf0f01234, 32'h0ff0ffff, 32'h00f01234);
    op_check("or", 4'd3, 32'hf0000000, 32'h0000000f, 32'hf000000f);
    op_check("xor", 4'd4, 32'haaaa5555, 32'hffff0000, 32'h55555555);
    op_check("slt", 4'd5, 32'hffffffff, 32'd1, 32'd1);
    op_check("sltu", 4'd6, 32'hffffffff, 32'd1, 32'd0);
    op_check("sll", 4'd7, 32'd1, 32'h21, 32'd2);
    op_check("srl", 4'd8, 32'h80000000, 32'h24, 32'h08000000);
    op_check("sra", 4'd9, 32'h80000000, 32'h24, 32'hf8000000);
    op_check("undef", 4'hf, 32'd1, 32'd2, 32'hfacebeec);
    chk("ops_nbc", 32'(bcast_q.size()), 32'd11);

    // Backpressure.
    bcast_q.delete();
    cdb_grant = 1'b0;
    set_pkt(4'd0, 32'd10, 32'd1, 6'd1, 5'd1);
    tick();
    set_pkt(4'd0, 32'd20, 32'd2, 6'd2, 5'd2);
    tick();
    set_pkt(4'd0, 32'd30, 32'd3, 6'd3, 5'd3);
    #1;
    chk("bp_ready0", 32'(issue_ready), 32'd0);
    chk("bp_req", 32'(cdb_req), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_data", cdb_data, 32'd11);
      chk("bp_hold_preg", 32'(cdb_preg), 32'd1);
      chk("bp_hold_ready", 32'(issue_ready), 32'd0);
    end
    cdb_grant = 1'b1;
    tick();
    chk("bp_pop1_data", cdb_data, 32'd22);
    chk("bp_pop1_ready", 32'(issue_ready), 32'd1);
    tick();
    issue_valid = 1'b0;
    chk("bp_third_data", cdb_data, 32'd33);
    chk("bp_third_rob", 32'(cdb_rob_idx), 32'd3);
    tick();
    chk("bp_busy", 32'(busy), 32'd0);
    chk("bp_nbc", 32'(bcast_q.size()), 32'd3);
    if (bcast_q.size() == 3) begin
      chk("bp_ord0", bcast_q[0], 32'd11);
      chk("bp_ord1", bcast_q[1], 32'd22);
      chk("bp_ord2", bcast_q[2], 32'd33);
    end

    // Simultaneous push/pop at count 1.
    bcast_q.delete();
    cdb_grant = 1'b0;
    set_pkt(4'd0, 32'd100, 32'd0, 6'd10, 5'd10);
    tick();
    cdb_grant = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      set_pkt(4'd0, 32'(100 + i), 32'd0, 6'(10 + i), 5'(10 + i));
      tick();
      chk("pp_busy", 32'(busy), 32'd1);
      chk("pp_ready", 32'(issue_ready), 32'd1);
      chk("pp_data", cdb_data, 32'(100 + i));
    end
    issue_valid = 1'b0;
    tick();
    chk("pp_empty", 32'(busy), 32'd0);
    chk("pp_nbc", 32'(bcast_q.size()), 32'd5);
    if (bcast_q.size() == 5) begin
      for (int i = 0; i < 5; i++) chk("pp_ord", bcast_q[i], 32'(100 + i));
    end

    // Squash with two entries, same-cycle issue and grant.
    bcast_q.delete();
    cdb_grant = 1'b0;
    set_pkt(4'd0, 32'd50, 32'd0, 6'd20, 5'd20);
    tick();
    set_pkt(4'd0, 32'd60, 32'd0, 6'd21, 5'd21);
    tick();
    set_pkt(4'd0, 32'd7, 32'd7, 6'd22, 5'd22);
    cdb_grant = 1'b1;
    squash = 1'b1;
    #1;
    chk("sq_req_forced", 32'(cdb_req), 32'd0);
    tick();
    squash = 1'b0;
    issue_valid = 1'b0;
    cdb_grant = 1'b0;
    #1;
    chk("sq_busy", 32'(busy), 32'd0);
    chk("sq_req", 32'(cdb_req), 32'd0);
    chk("sq_data", cdb_data, 32'd0);
    chk("sq_nbc", 32'(bcast_q.size()), 32'd0);
    set_pkt(4'd0, 32'd1, 32'd1, 6'd23, 5'd23);
    tick();
    issue_valid = 1'b0;
    chk("sq_next_req", 32'(cdb_req), 32'd1);
    chk("sq_next_data", cdb_data, 32'd2);
    chk("sq_next_preg", 32'(cdb_preg), 32'd23);
    cdb_grant = 1'b1;
    tick();
    chk("sq_next_busy", 32'(busy), 32'd0);
    chk("sq_next_nbc", 32'(bcast_q.size()), 32'd1);

    // Reset mid-stream.
    bcast_q.delete();
    cdb_grant = 1'b0;
    set_pkt(4'd0, 32'd40, 32'd0, 6'd30, 5'd30);
    tick();
    set_pkt(4'd0, 32'd41, 32'd0, 6'd31, 5'd31);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    issue_valid = 1'b0;
    #1;
    chk("mr_req", 32'(cdb_req), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_ready", 32'(issue_ready), 32'd1);
    chk("mr_data", cdb_data, 32'd0);
    chk("mr_preg", 32'(cdb_preg), 32'd0);
    chk("mr_rob", 32'(cdb_rob_idx), 32'd0);
    cdb_grant = 1'b1;
    tick();
    chk("mr_still_empty", 32'(busy), 32'd0);
    chk("mr_nbc", 32'(bcast_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
